countdown_timer: RTL and testbench

Minute/second countdown timer for the multi-purpose watch: the down-counting counterpart of the up-counting clock chain. It consumes the same one-cycle `clk_sec` tick that drives the watch's minute generation. It holds a BCD MM:SS value loaded from the set-mode inputs and decrements it once per tick while running. It signals expiry on `alarm` for the buzzer/LED logic and presents BCD digits to the FND display mux.

---
 rtl/countdown_timer_pkg.sv | 9 +
 rtl/countdown_timer_if.sv | 14 +
 rtl/countdown_timer_bcd_down_digit.sv | 20 ++
 rtl/countdown_timer.sv | 54 +++++
 tb/tb_countdown_timer.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/countdown_timer_pkg.sv
// countdown_timer_pkg: shared state enum, BCD digit limits and the BCD nibble clamp used on load
package countdown_timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam logic [3:0] BCD_UNIT_MAX = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  function automatic logic [7:0] bcd_clamp(input logic [7:0] v);
    return {v[7:4] > SEC_TENS_MAX ? SEC_TENS_MAX : v[7:4], v[3:0] > BCD_UNIT_MAX ? BCD_UNIT_MAX : v[3:0]};
  endfunction
endpackage

// File: rtl/countdown_timer_if.sv
// countdown_timer_if: timer bus; master drives clk_sec/load/start_stop/set_min/set_sec, slave returns min_bcd/sec_bcd/running/alarm
interface countdown_timer_if;
  logic       clk_sec;
  logic       load;
  logic       start_stop;
  logic [7:0] set_min;
  logic [7:0] set_sec;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       alarm;
  modport master(output clk_sec, load, start_stop, set_min, set_sec, input min_bcd, sec_bcd, running, alarm);
  modport slave(input clk_sec, load, start_stop, set_min, set_sec, output min_bcd, sec_bcd, running, alarm);
endinterface

// File: rtl/countdown_timer_bcd_down_digit.sv
// bcd_down_digit: one BCD down-counting digit wrapping 0->WRAP; ports clk, rst, i_ld/i_val load, i_dec decrement, o_val digit, o_borrow borrow-out, o_zero is-zero
module bcd_down_digit #(
  parameter logic [3:0] WRAP = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ld,
  input  logic       i_dec,
  input  logic [3:0] i_val,
  output logic [3:0] o_val,
  output logic       o_borrow,
  output logic       o_zero
);
  logic [3:0] r_val;
  always_ff @(posedge clk)
    r_val <= rst ? 4'd0 : i_ld ? i_val : i_dec ? (o_zero ? WRAP : r_val - 4'd1) : r_val;
  assign o_val    = r_val;
  assign o_zero   = r_val == 4'd0;
  assign o_borrow = i_dec & o_zero;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: BCD MM:SS countdown (clk, reset_p sync active-high, bus slave: clk_sec/load/start_stop/set_min/set_sec in, min_bcd/sec_bcd/running/alarm out); COUNTDOWN_ALARM_HOLD_EN holds alarm through DONE, else a 1-cycle alarm
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int MAX_MIN = 59
) (
  input logic               clk,
  input logic               reset_p,
  countdown_timer_if.slave  bus
);
  localparam logic [7:0] MAX_BCD = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  state_t      r_state, w_next;
  logic        r_running, r_alarm, w_alarm_nxt, w_tick, w_last;
  logic [7:0]  w_min_n;
  logic [15:0] w_ld_val;
  logic [3:0]  w_dig [4];
  logic [3:0]  w_zero;
  logic [4:0]  w_dec;
  assign w_min_n  = bcd_clamp(bus.set_min);
  assign w_ld_val = {w_min_n > MAX_BCD ? MAX_BCD : w_min_n, bcd_clamp(bus.set_sec)};
  assign w_tick   = r_state == RUN && bus.clk_sec && !bus.load && !bus.start_stop;
  assign w_last   = w_tick && (&w_zero[3:1]) && w_dig[0] == 4'd1;
  assign w_dec[0] = w_tick;
  for (genvar d = 0; d < 4; d++) begin : g_dig
    bcd_down_digit #(.WRAP(d == 1 ? SEC_TENS_MAX : BCD_UNIT_MAX)) u_dig (
      .clk(clk), .rst(reset_p), .i_ld(bus.load), .i_dec(w_dec[d]), .i_val(w_ld_val[4*d +: 4]),
      .o_val(w_dig[d]), .o_borrow(w_dec[d+1]), .o_zero(w_zero[d])
    );
  end
  always_comb begin
    w_next = bus.load ? IDLE :
             bus.start_stop ? (r_state == RUN ? PAUSE :
                               r_state == PAUSE ? RUN :
                               (r_state == IDLE && !(&w_zero)) ? RUN : IDLE) :
             w_last ? DONE : r_state;
  end
`ifdef COUNTDOWN_ALARM_HOLD_EN
  assign w_alarm_nxt = w_last | (r_alarm & ~bus.load & ~bus.start_stop);
`else
  assign w_alarm_nxt = w_last;
`endif
  always_ff @(posedge clk) begin
    r_state   <= reset_p ? IDLE : w_next;
    r_running <= !reset_p && w_next == RUN;
    r_alarm   <= !reset_p && w_alarm_nxt;
  end
  // expiry stops the chain at 00:00, so the minutes-tens digit can never borrow
  always_ff @(posedge clk)
    if (!reset_p) assert (!w_dec[4]);
  assign bus.min_bcd = {w_dig[3], w_dig[2]};
  assign bus.sec_bcd = {w_dig[1], w_dig[0]};
  assign bus.running = r_running;
  assign bus.alarm   = r_alarm;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed self-checking bench for countdown_timer
module tb_countdown_timer;
`ifdef COUNTDOWN_ALARM_HOLD_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_p = 1'b1;
  int n = 0;
  int p = 0;
  logic [17:0] e;
  countdown_timer_if bus();
  countdown_timer #(.MAX_MIN(59)) dut (.clk(clk), .reset_p(reset_p), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [17:0] o();
    return {bus.min_bcd, bus.sec_bcd, bus.running, bus.alarm};
  endfunction
  task automatic step(input logic ld, input logic ss, input logic tk);
    bus.load = ld;
    bus.start_stop = ss;
    bus.clk_sec = tk;
    @(posedge clk);
    #1;
    bus.load = 1'b0;
    bus.start_stop = 1'b0;
    bus.clk_sec = 1'b0;
  endtask
  task automatic ld(input logic [7:0] m, input logic [7:0] s);
    bus.set_min = m;
    bus.set_sec = s;
    step(1'b1, 1'b0, 1'b0);
  endtask
  task automatic test_reset();
    reset_p = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    e = 18'h0; n++; if (o() !== e) $display("FAIL reset_state got=%h exp=%h", o(), e); else p++;
    reset_p = 1'b0;
  endtask
  task automatic test_short_expiry();
    ld(8'h00, 8'h03);
    e = {8'h00, 8'h03, 2'b00}; n++; if (o() !== e) $display("FAIL short_load got=%h exp=%h", o(), e); else p++;
    step(1'b0, 1'b1, 1'b0);
    e = {8'h00, 8'h03, 2'b10}; n++; if (o() !== e) $display("FAIL short_start got=%h exp=%h", o(), e); else p++;
    step(1'b0, 1'b0, 1'b1);
    e = {8'h00, 8'h02, 2'b10}; n++; if (o() !== e) $display("FAIL short_tick1 got=%h exp=%h", o(), e); else p++;
    step(1'b0, 1'b0, 1'b1);
    e = {8'h00, 8'h01, 2'b10}; n++; if (o() !== e) $display("FAIL short_tick2 got=%h exp=%h", o(), e); else p++;
    step(1'b0, 1'b0, 1'b1);
    e = {8'h00, 8'h00, 2'b01}; n++; if (o() !== e) $display("FAIL short_expire got=%h exp=%h", o(), e); else p++;
    step(1'b0, 1'b0, 1'b1);
    e = {16'h0, 1'b0, HOLD}; n++; if (o() !== e) $display("FAIL done_tick_ignored got=%h exp=%h", o(), e); else p++;
    step(1'b0, 1'b1, 1'b0);
    e = 18'h0; n++; if (o() !== e) $display("FAIL done_ack got=%h exp=%h", o(), e); else p++;
    step(1'b0, 1'b1, 1'b0);
    e = 18'h0; n++; if (o() !== e) $display("FAIL idle_zero_start got=%h exp=%h", o(), e); else p++;
  endtask
  task automatic test_back_to_back();
    ld(8'h01, 8'h00);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    e = {8'h00, 8'h59, 2'b10}; n++; if (o() !== e) $display("FAIL min_borrow got=%h exp=%h", o(), e); else p++;
    for (int i = 0; i < 58; i++) step(1'b0, 1'b0, 1'b1);
    e = {8'h00, 8'h01, 2'b10}; n++; if (o() !== e) $display("FAIL b2b_58 got=%h exp=%h", o(), e); else p++;
    step(1'b0, 1'b0, 1'b1);
    e = {8'h00, 8'h00, 2'b01}; n++; if (o() !== e) $display("FAIL b2b_expire got=%h exp=%h", o(), e); else p++;
    step(1'b0, 1'b1, 1'b0);
    ld(8'h10, 8'h00);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    e = {8'h09, 8'h59, 2'b10}; n++; if (o() !== e) $display("FAIL min_tens_borrow got=%h exp=%h", o(), e); else p++;
  endtask
  task automatic test_pause();
    ld(8'h00, 8'h10);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    e = {8'h00, 8'h08, 2'b10}; n++; if (o() !== e) $display("FAIL pause_pre got=%h exp=%h", o(), e); else p++;
    step(1'b0, 1'b1, 1'b0);
    e = {8'h00, 8'h08, 2'b00}; n++; if (o() !== e) $display("FAIL pause_enter got=%h exp=%h", o(), e); else p++;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
    e = {8'h00, 8'h08, 2'b00}; n++; if (o() !== e) $display("FAIL pause_hold got=%h exp=%h", o(), e); else p++;
    step(1'b0, 1'b1, 1'b1);
    e = {8'h00, 8'h08, 2'b10}; n++; if (o() !== e) $display("FAIL resume_tick_ignored got=%h exp=%h", o(), e); else p++;
    step(1'b0, 1'b0, 1'b1);
    e = {8'h00, 8'h07, 2'b10}; n++; if (o() !== e) $display("FAIL resume_count got=%h exp=%h", o(), e); else p++;
  endtask
  task automatic test_clamp();
    ld(8'h7A, 8'h6F);
    e = {8'h59, 8'h59, 2'b00}; n++; if (o() !== e) $display("FAIL clamp_load got=%h exp=%h", o(), e); else p++;
    ld(8'h3C, 8'h2B);
    e = {8'h39, 8'h29, 2'b00}; n++; if (o() !== e) $display("FAIL clamp_units got=%h exp=%h", o(), e); else p++;
    step(1'b0, 1'b0, 1'b1);
    e = {8'h39, 8'h29, 2'b00}; n++; if (o() !== e) $display("FAIL idle_tick_ignored got=%h exp=%h", o(), e); else p++;
  endtask
  task automatic test_alarm_width();
    int c = 0;
    ld(8'h00, 8'h01);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    c += int'(bus.alarm);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      c += int'(bus.alarm);
    end
    n++; if (c !== (HOLD ? 21 : 1)) $display("FAIL alarm_width got=%0d exp=%0d", c, HOLD ? 21 : 1); else p++;
    e = {16'h0, 1'b0, HOLD}; n++; if (o() !== e) $display("FAIL done_wait got=%h exp=%h", o(), e); else p++;
    step(1'b0, 1'b1, 1'b0);
    e = 18'h0; n++; if (o() !== e) $display("FAIL alarm_ack got=%h exp=%h", o(), e); else p++;
    ld(8'h00, 8'h01);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    bus.set_min = 8'h00;
    bus.set_sec = 8'h05;
    step(1'b1, 1'b0, 1'b0);
    e = {8'h00, 8'h05, 2'b00}; n++; if (o() !== e) $display("FAIL load_clears_alarm got=%h exp=%h", o(), e); else p++;
  endtask
  task automatic test_reset_midrun();
    ld(8'h05, 8'h30);
    step(1'b0, 1'b1, 1'b0);
    e = {8'h05, 8'h30, 2'b10}; n++; if (o() !== e) $display("FAIL run_0530 got=%h exp=%h", o(), e); else p++;
    reset_p = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    reset_p = 1'b0;
    e = 18'h0; n++; if (o() !== e) $display("FAIL reset_midrun got=%h exp=%h", o(), e); else p++;
    step(1'b0, 1'b1, 1'b0);
    e = 18'h0; n++; if (o() !== e) $display("FAIL reset_then_idle got=%h exp=%h", o(), e); else p++;
  endtask
  task automatic test_load_priority();
    ld(8'h05, 8'h30);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    e = {8'h05, 8'h29, 2'b10}; n++; if (o() !== e) $display("FAIL tick_0529 got=%h exp=%h", o(), e); else p++;
    bus.set_min = 8'h12;
    bus.set_sec = 8'h34;
    step(1'b1, 1'b1, 1'b1);
    e = {8'h12, 8'h34, 2'b00}; n++; if (o() !== e) $display("FAIL load_wins got=%h exp=%h", o(), e); else p++;
  endtask
  initial begin
    bus.load = 1'b0;
    bus.start_stop = 1'b0;
    bus.clk_sec = 1'b0;
    bus.set_min = 8'h00;
    bus.set_sec = 8'h00;
    test_reset();
    test_short_expiry();
    test_back_to_back();
    test_pause();
    test_clamp();
    test_alarm_width();
    test_reset_midrun();
    test_load_priority();
    $display("%0d/%0d checks passed", p, n);
    $finish;
  end
endmodule
